id_issue_queue: RTL and testbench
=================================

ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of instruction address.
REQ-002 Parameter INST_WIDTH, default 32, width of instruction word (MIPS field layout, opcode in bits 31:26).
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 Parameter CNT_WIDTH, default 16, width of stall-cycle counter.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 if_valid  in  1  IF offers an instruction this cycle.
REQ-008 if_addr  in  ADDR_WIDTH  PC of offered instruction.
REQ-009 if_inst  in  INST_WIDTH  offered instruction word.
REQ-010 if_ready  out  1  queue accepts an instruction; 1 iff count < DEPTH.
REQ-011 flush  in  1  branch taken; discard all queued and incoming instructions.
REQ-012 ex_load_valid  in  1  EX stage holds a load.
REQ-013 ex_load_reg  in  5  destination register of that load.
REQ-014 dec_valid  out  1  head instruction issued to decode.
REQ-015 dec_ready  in  1  downstream decode accepts head.
REQ-016 dec_addr  out  ADDR_WIDTH  PC of head; 0 when queue empty.
REQ-017 dec_inst  out  INST_WIDTH  head instruction; 0 (NOP) when queue empty.
REQ-018 stall_request  out  1  load-use hazard on head this cycle.
REQ-019 count  out  log2(DEPTH)+1  number of occupied entries.
REQ-020 stall_cycles  out  CNT_WIDTH  saturating count of hazard cycles since reset.

Function
REQ-021 Queue SHALL be circular FIFO of {addr, inst}; write and read pointers wrap modulo DEPTH.
REQ-022 Push SHALL occur when if_valid && if_ready && !flush; entry written at write pointer, pointer +1.
REQ-023 Hazard SHALL be: queue non-empty && ex_load_valid && ex_load_reg != 0 && (ex_load_reg == head rs [25:21] || (head reads rt && ex_load_reg == head rt [20:16])).
REQ-024 Head reads rt SHALL be true for opcode 0 (R-type), BEQ, BNE and all stores (opcodes 0x28-0x2B); false otherwise.
REQ-025 stall_request SHALL equal hazard combinationally; dec_valid SHALL be (count != 0) && !hazard && !flush.
REQ-026 Pop SHALL occur when dec_valid && dec_ready; read pointer +1.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-028 if_ready SHALL depend only on registered count (no same-cycle pop pass-through); full queue rejects push even when popping.
REQ-029 flush SHALL, at next edge, set both pointers and count to 0; concurrent push and pop are suppressed.
REQ-030 Latency: instruction pushed at edge N SHALL be visible on dec_* from cycle N+1 (no bypass when empty).
REQ-031 stall_cycles SHALL increment by 1 each cycle stall_request is 1 and saturate at all-ones.
REQ-032 Entry contents SHALL be unchanged while held; dec_addr/dec_inst stable while dec_valid && !dec_ready.

Reset
REQ-033 rst high SHALL immediately force pointers, count, stall_cycles to 0; dec_valid 0, dec_addr 0, dec_inst 0, stall_request 0, if_ready 1.
REQ-034 rst asserted mid-operation SHALL discard all queued entries; storage array need not be cleared.
REQ-035 First push SHALL be accepted on first rising edge after rst deasserts.

Verification
REQ-036 Fill: DEPTH=4, push 0x00400000..0x0040000C with dec_ready=0 -> count 4, if_ready 0, 5th offer not accepted, dec_addr 0x00400000.
REQ-037 Wrap: push/pop continuously 10 instructions, dec_ready=1 -> issued in order, count stays 1, pointers wrap twice, no loss.
REQ-038 Hazard: head 0x8C010000-style consumer "addu $3,$1,$2" (0x00221821), ex_load_valid=1, ex_load_reg=1 for 2 cycles -> stall_request 1, dec_valid 0, stall_cycles 2, then issue.
REQ-039 No hazard on $0 or unread rt: ex_load_reg=0, or head "lui $1,0x1234" with ex_load_reg=1 -> stall_request 0.
REQ-040 Flush: 3 entries queued, flush with if_valid=1 and dec_ready=1 -> next cycle count 0, dec_valid 0, dec_inst 0, offered instruction dropped.
REQ-041 Async reset: assert rst between edges with count 3 -> count 0, dec_valid 0 before next edge.

Source files
------------

// File: rtl/id_issue_queue_if.sv
// Handshake bundle between fetch, the decode issue queue and its consumers.
interface id_issue_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
);
  localparam int unsigned COUNT_WIDTH = $clog2(DEPTH) + 1;

  logic                   if_valid;
  logic [ADDR_WIDTH-1:0]  if_addr;
  logic [INST_WIDTH-1:0]  if_inst;
  logic                   if_ready;
  logic                   flush;
  logic                   ex_load_valid;
  logic [4:0]             ex_load_reg;
  logic                   dec_valid;
  logic                   dec_ready;
  logic [ADDR_WIDTH-1:0]  dec_addr;
  logic [INST_WIDTH-1:0]  dec_inst;
  logic                   stall_request;
  logic [COUNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0]   stall_cycles;

  // Environment side: fetch, EX hazard info and decode acceptance.
  modport master (
    output if_valid, if_addr, if_inst, flush, ex_load_valid, ex_load_reg, dec_ready,
    input  if_ready, dec_valid, dec_addr, dec_inst, stall_request, count, stall_cycles
  );

  // Queue side.
  modport slave (
    input  if_valid, if_addr, if_inst, flush, ex_load_valid, ex_load_reg, dec_ready,
    output if_ready, dec_valid, dec_addr, dec_inst, stall_request, count, stall_cycles
  );
endinterface

// File: rtl/id_issue_queue.sv
// Decode-stage issue queue: circular FIFO of {pc, inst} between IF and decode,
// holding the head back on a load-use hazard against the load in EX.
module id_issue_queue #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            rst,
  id_issue_queue_if.slave bus
);
  localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);
  localparam int unsigned COUNT_WIDTH = PTR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0]  addr_mem_q [DEPTH];
  logic [INST_WIDTH-1:0]  inst_mem_q [DEPTH];

  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

  logic                   empty_c;
  logic                   ready_c;
  logic [ADDR_WIDTH-1:0]  head_addr_c;
  logic [INST_WIDTH-1:0]  head_inst_c;
  logic [5:0]             opcode_c;
  logic [4:0]             rs_c;
  logic [4:0]             rt_c;
  logic                   reads_rt_c;
  logic                   hazard_c;
  logic                   issue_c;
  logic                   push_c;
  logic                   pop_c;

  assign empty_c     = (count_q == '0);
  assign ready_c     = (count_q < COUNT_WIDTH'(DEPTH));
  assign head_addr_c = addr_mem_q[rd_ptr_q];
  assign head_inst_c = inst_mem_q[rd_ptr_q];
  assign opcode_c    = head_inst_c[31:26];
  assign rs_c        = head_inst_c[25:21];
  assign rt_c        = head_inst_c[20:16];

  // rt is a source for R-type, BEQ/BNE and stores; a destination or unused otherwise.
  always_comb begin
    reads_rt_c = 1'b0;
    case (opcode_c)
      6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2A, 6'h2B: reads_rt_c = 1'b1;
      default:                                         reads_rt_c = 1'b0;
    endcase
  end

  // Load-use hazard between the load in EX and the queue head; $0 never conflicts.
  assign hazard_c = !empty_c && bus.ex_load_valid && (bus.ex_load_reg != 5'd0) &&
                    ((bus.ex_load_reg == rs_c) ||
                     (reads_rt_c && (bus.ex_load_reg == rt_c)));

  assign issue_c = !empty_c && !hazard_c && !bus.flush;
  assign push_c  = bus.if_valid && ready_c && !bus.flush;
  assign pop_c   = issue_c && bus.dec_ready;

  // Next-state for pointers, occupancy and the saturating stall counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + COUNT_WIDTH'(1);
        2'b01:   count_d = count_q - COUNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
    if (hazard_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  // Control state register; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Entry storage; left uncleared on reset since the pointers make it invisible.
  always_ff @(posedge clk) begin
    if (push_c) begin
      addr_mem_q[wr_ptr_q] <= bus.if_addr;
      inst_mem_q[wr_ptr_q] <= bus.if_inst;
    end
  end

  assign bus.if_ready      = ready_c;
  assign bus.dec_valid     = issue_c;
  assign bus.dec_addr      = empty_c ? '0 : head_addr_c;
  assign bus.dec_inst      = empty_c ? '0 : head_inst_c;
  assign bus.stall_request = hazard_c;
  assign bus.count         = count_q;
  assign bus.stall_cycles  = stall_cnt_q;
endmodule

// File: tb/tb_id_issue_queue.sv
// Self-checking bench for id_issue_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_id_issue_queue;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned CNT_WIDTH  = 16;
  localparam int          STALL_MAX  = (1 << CNT_WIDTH) - 1;

  logic clk;
  logic rst;

  id_issue_queue_if #(
    .ADDR_WIDTH(ADDR_WIDTH), .INST_WIDTH(INST_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) bus ();

  id_issue_queue #(
    .ADDR_WIDTH(ADDR_WIDTH), .INST_WIDTH(INST_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: occupied entries in issue order, plus hazard-cycle tally.
  bit [63:0] mq[$];
  int        stall_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_hazard(bit [31:0] ins, bit lv, bit [4:0] lr);
    int op;
    int rs;
    int rt;
    bit uses_rt;
    op      = int'(ins[31:26]);
    rs      = int'(ins[25:21]);
    rt      = int'(ins[20:16]);
    uses_rt = op inside {0, 4, 5, 40, 41, 42, 43};
    return lv && (lr != 0) && ((int'(lr) == rs) || (uses_rt && (int'(lr) == rt)));
  endfunction

  // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic step(input bit v, input bit [31:0] a, input bit [31:0] ins, input bit fl,
                      input bit lv, input bit [4:0] lr, input bit dr);
    bit [63:0] head;
    bit        nonempty;
    bit        hz;
    bit        exp_rdy;
    bit        exp_dv;
    bit        do_push;
    bit        do_pop;
    bus.if_valid      = v;
    bus.if_addr       = a;
    bus.if_inst       = ins;
    bus.flush         = fl;
    bus.ex_load_valid = lv;
    bus.ex_load_reg   = lr;
    bus.dec_ready     = dr;
    nonempty = (mq.size() > 0);
    head     = nonempty ? mq[0] : 64'd0;
    hz       = nonempty && model_hazard(head[31:0], lv, lr);
    exp_rdy  = (mq.size() < DEPTH);
    exp_dv   = nonempty && !hz && !fl;
    @(negedge clk);
    check("if_ready",      64'(bus.if_ready),      64'(exp_rdy));
    check("count",         64'(bus.count),         64'(mq.size()));
    check("dec_valid",     64'(bus.dec_valid),     64'(exp_dv));
    check("dec_addr",      64'(bus.dec_addr),      64'(head[63:32]));
    check("dec_inst",      64'(bus.dec_inst),      64'(head[31:0]));
    check("stall_request", 64'(bus.stall_request), 64'(hz));
    check("stall_cycles",  64'(bus.stall_cycles),  64'(stall_cnt));
    @(posedge clk);
    do_push = v && exp_rdy && !fl;
    do_pop  = exp_dv && dr;
    if (fl) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({a, ins});
    end
    if (hz && stall_cnt != STALL_MAX) stall_cnt++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid      = 1'b0;
    bus.if_addr       = '0;
    bus.if_inst       = '0;
    bus.flush         = 1'b0;
    bus.ex_load_valid = 1'b0;
    bus.ex_load_reg   = '0;
    bus.dec_ready     = 1'b0;
  endtask

  // Reset held over two edges; released at posedge+1 so the next edge can push.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_count",     64'(bus.count),         64'd0);
    check("rst_if_ready",  64'(bus.if_ready),      64'd1);
    check("rst_dec_valid", 64'(bus.dec_valid),     64'd0);
    check("rst_dec_inst",  64'(bus.dec_inst),      64'd0);
    check("rst_dec_addr",  64'(bus.dec_addr),      64'd0);
    check("rst_stall_req", 64'(bus.stall_request), 64'd0);
    check("rst_stall_cyc", 64'(bus.stall_cycles),  64'd0);
    mq.delete();
    stall_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reset pulse between edges: outputs must clear before the next edge.
  task automatic async_reset();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check("arst_count",     64'(bus.count),        64'd0);
    check("arst_dec_valid", 64'(bus.dec_valid),    64'd0);
    check("arst_if_ready",  64'(bus.if_ready),     64'd1);
    check("arst_dec_inst",  64'(bus.dec_inst),     64'd0);
    check("arst_stall_cyc", 64'(bus.stall_cycles), 64'd0);
    mq.delete();
    stall_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic bit [31:0] rand_inst();
    bit [5:0] ops [8] = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0F, 6'h08, 6'h28};
    bit [5:0] op;
    bit [4:0] rs;
    bit [4:0] rt;
    bit [15:0] lo;
    op = ops[$urandom_range(7, 0)];
    rs = 5'($urandom_range(3, 0));
    rt = 5'($urandom_range(3, 0));
    lo = 16'($urandom);
    return {op, rs, rt, lo};
  endfunction

  localparam bit [31:0] ADDU = 32'h0022_1821;
  localparam bit [31:0] LUI  = 32'h3C01_1234;

  initial begin
    rst = 1'b0;
    idle_inputs();
    do_reset();

    // Fill to DEPTH with no drain; fifth offer must bounce.
    for (int i = 0; i < 5; i++)
      step(1, 32'h0040_0000 + 32'(4 * i), 32'h2000_0000 + 32'(i), 0, 0, 0, 0);
    check("fill_count",    64'(bus.count),    64'd4);
    check("fill_if_ready", 64'(bus.if_ready), 64'd0);
    check("fill_dec_addr", 64'(bus.dec_addr), 64'h0040_0000);
    step(0, 0, 0, 1, 0, 0, 0);

    // Load-use hazard on rs for two cycles, then issue.
    step(1, 32'h0040_0100, ADDU, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5'd1, 1);
    step(0, 0, 0, 0, 1, 5'd1, 1);
    check("haz_stall_cycles", 64'(bus.stall_cycles), 64'd2);
    step(0, 0, 0, 0, 0, 0, 1);
    check("haz_drained", 64'(bus.count), 64'd0);

    // $0 never hazards; lui does not read rt.
    step(1, 32'h0040_0200, ADDU, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5'd0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h0040_0204, LUI, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5'd1, 1);
    check("lui_stall_cycles", 64'(bus.stall_cycles), 64'd2);

    // Streaming: ten instructions through with continuous drain, pointers wrap.
    for (int i = 0; i < 10; i++)
      step(1, 32'h0040_1000 + 32'(4 * i), 32'h2400_0000 + 32'(i), 0, 0, 0, 1);
    check("wrap_count", 64'(bus.count), 64'd1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Flush with an offer and a ready consumer pending.
    for (int i = 0; i < 3; i++)
      step(1, 32'h0040_2000 + 32'(4 * i), 32'h2500_0000 + 32'(i), 0, 0, 0, 0);
    step(1, 32'h0040_200C, 32'h2500_0003, 1, 0, 0, 1);
    check("flush_count",     64'(bus.count),     64'd0);
    check("flush_dec_valid", 64'(bus.dec_valid), 64'd0);
    check("flush_dec_inst",  64'(bus.dec_inst),  64'd0);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++)
      step(1, 32'h0040_3000 + 32'(4 * i), 32'h2600_0000 + 32'(i), 0, 0, 0, 0);
    check("pre_arst_count", 64'(bus.count), 64'd3);
    async_reset();
    step(1, 32'h0040_4000, 32'h2700_0000, 0, 0, 0, 0);
    check("post_rst_push", 64'(bus.count), 64'd1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(599, 0) == 0) async_reset();
      step(($urandom_range(9, 0) < 7), 32'h0050_0000 + 32'(4 * n), rand_inst(),
           ($urandom_range(24, 0) == 0), ($urandom_range(9, 0) < 4),
           5'($urandom_range(3, 0)), ($urandom_range(9, 0) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
